// File: rtl/serial_sub_engine.sv
// serial_sub_engine: digit-serial subtractor. Computes diff = (a - b) mod 2^WIDTH
// and an unsigned borrow flag, DIGIT bits per cycle, LSB first, through a single
// borrow flop. Valid/ready handshakes on both the operand and the result side.
// WIDTH must be a multiple of DIGIT.
module serial_sub_engine #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;        // minuend shift register
    logic [WIDTH-1:0] b_q, b_d;        // subtrahend shift register
    logic [WIDTH-1:0] res_q, res_d;    // partial result, filled from the top
    logic [WIDTH-1:0] diff_q, diff_d;  // published result, held until next job ends
    logic             brw_q, brw_d;    // running borrow between digits
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT:0]         step;      // {borrow_out, digit_result}
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;

    // One digit of subtract-with-borrow and the result register after shifting it in.
    always_comb begin
        step     = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw_q};
        res_cat  = {step[DIGIT-1:0], res_q};
        res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
    end

    // Next-state and datapath control for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned;
        // without this, synthesis infers latches for the untouched branches.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        brw_d    = brw_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                res_d = res_next;
                brw_d = step[DIGIT];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // Outputs only move on this transition; IDLE keeps the last result.
                    diff_d   = res_next;
                    borrow_d = step[DIGIT];
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; asynchronous reset discards any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values; blocking here would create order-dependent simulation.
        if (!rst_n) begin
            // NOTE: every flop is reset, including the operand shifters, so the
            // engine restarts identically to power-up after a mid-job reset.
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            brw_q    <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            brw_q    <= brw_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    // All outputs come straight from flops: no input-to-output combinational path.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;

endmodule

// File: doc/serial_sub_engine.md
Name: serial_sub_engine

Overview:
Multi-cycle subtractor, the inverse-direction companion of the combinational 8-bit ripple adder in the FHE benchmark set. It computes diff = (a - b) mod 2^WIDTH and an unsigned borrow flag (a < b).
- Processes DIGIT bits per cycle, LSB first, through a single borrow flop, which keeps the per-cycle logic depth minimal.
- Valid/ready handshakes on both the input and the output side.
- Sits between an operand source and a result consumer in the arithmetic benchmark datapath.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
DIGIT, 1, bits processed per cycle; N = WIDTH/DIGIT compute cycles.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  engine can accept operands.
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
diff  output  WIDTH  (a - b) mod 2^WIDTH.
borrow  output  1  1 iff a < b (unsigned).
busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, busy=0, digit counter=0, internal borrow flop=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a and b into shift registers, clear the borrow flop, set count=0, go to RUN.
  - RUN: in_ready=0. Each cycle, subtract the low DIGIT bits of the a-shift minus the b-shift minus the borrow flop. Shift the DIGIT result bits into the top of the result register, update the borrow flop, count++. When count reaches N-1, go to DONE.
  - DONE: out_valid=1. diff and borrow are stable and held. On out_valid&&out_ready, go to IDLE.
- Timing:
  - Operands accepted on edge t → out_valid high after edge t+N.
  - Minimum spacing between accepts is N+2 cycles; no accept is allowed in the same cycle as the output handshake.
- Arithmetic: a DIGIT-wide subtract with borrow-in gives a DIGIT-bit result and a borrow-out. The final borrow flop value is the borrow output. Overflow wraps modulo 2^WIDTH and is never flagged otherwise.
- in_valid while in_ready=0 is ignored; a and b may change freely outside the accept cycle.
- out_ready low in DONE: hold indefinitely. out_ready high outside DONE has no effect.
- diff and borrow change only on the RUN→DONE transition. In IDLE they retain the last result (0 after reset).
- Reset asserted mid-RUN or mid-DONE: the result is discarded and all outputs return to reset values immediately (asynchronous). After reset deassertion the engine behaves as from power-up.
- No combinational path from any input to any output.

Test Plan:
- a=0x05, b=0x03, in_valid pulse at cycle 0, out_ready=1 → out_valid rises after 8 edges; diff=0x02, borrow=0; returns to IDLE next cycle.
- a=0x00, b=0x01 → diff=0xFF, borrow=1. a=0x80, b=0x7F → diff=0x01, borrow=0. a=0xAA, b=0xAA → diff=0x00, borrow=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid → diff, borrow and out_valid held stable; in_ready stays 0. The second operand pair presented during that window is not accepted until after IDLE is re-entered.
- in_valid held high with changing a/b during RUN → result reflects only the pair latched at the accept edge.
- rst_n low for 1 cycle at RUN count=3 → out_valid never asserts for that job; in_ready=1 and diff=0 right after reset. The next job, a=0x10, b=0x20, yields diff=0xF0, borrow=1.
- WIDTH=8, DIGIT=4 → latency 2 cycles; random 1000-pair sweep matches the reference model (a-b)&0xFF and a<b.
